// File: rtl/pipe_pkg.sv
// Shared definitions for the ID/EX issue controller: instruction classes,
// halt sequencing states and the per-class result latency.
package pipe_pkg;

  typedef enum logic [1:0] {
    CLS_ALU  = 2'b00,
    CLS_LOAD = 2'b01,
    CLS_LONG = 2'b10,
    CLS_HALT = 2'b11
  } op_class_t;

  typedef enum logic [1:0] {
    RUN    = 2'b00,
    DRAIN  = 2'b01,
    HALTED = 2'b10
  } state_t;

  // Cycles until an instruction's result can be forwarded. Long-op latency
  // is clamped so a zero request still occupies the unit for one cycle and
  // nothing exceeds what the counters can hold.
  function automatic int unsigned op_lat(op_class_t cls, int unsigned long_lat,
                                         int unsigned mem_lat, int unsigned max_lat);
    int unsigned lat;
    case (cls)
      CLS_LOAD: lat = 1 + mem_lat;
      CLS_LONG: begin
        if (long_lat == 0)            lat = 1;
        else if (long_lat > max_lat)  lat = max_lat;
        else                          lat = long_lat;
      end
      default:  lat = 1;
    endcase
    return lat;
  endfunction

endpackage

// File: rtl/sb_counter.sv
// One scoreboard entry: remaining cycles until the pending write to this
// register becomes forwardable. A new load overrides the countdown.
module sb_counter
  import pipe_pkg::*;
#(
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  input  logic          dec,
  output logic [CW-1:0] count,
  output logic          nz
);

  logic [CW-1:0] cnt_q;

  // Load has priority; otherwise count down towards zero and stop there.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_q <= cnt_q - CW'(1);
    end
  end

  assign count = cnt_q;
  assign nz    = (cnt_q != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// Issue controller between ID and EX: detects RAW/WAW/structural hazards
// from per-register countdowns, drives stall/bubble/flush and sequences the
// halt drain.
module hazard_scoreboard
  import pipe_pkg::*;
#(
  parameter int NREG       = 32,
  parameter int MEM_LAT    = 1,
  parameter int MAX_LAT    = 8,
  parameter int FWD_WINDOW = 1,
  localparam int RW = $clog2(NREG),
  localparam int CW = $clog2(MAX_LAT + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            id_valid,
  input  logic [RW-1:0]   id_rs1,
  input  logic [RW-1:0]   id_rs2,
  input  logic            id_use_rs1,
  input  logic            id_use_rs2,
  input  logic [RW-1:0]   id_rd,
  input  logic            id_we,
  input  logic [1:0]      id_class,
  input  logic [CW-1:0]   id_long_lat,
  input  logic            ex_redirect,
  output logic            issue,
  output logic            stall,
  output logic            bubble,
  output logic            flush_if_id,
  output logic            long_busy,
  output logic            halted,
  output logic [NREG-1:0] sb_pending
);

  if (1 + MEM_LAT > MAX_LAT) begin : g_lat_check
    $error("hazard_scoreboard: load latency 1+MEM_LAT exceeds MAX_LAT");
  end

  localparam logic [CW-1:0] FWD_C = CW'(FWD_WINDOW);

  op_class_t       cls;
  logic [CW-1:0]   op_l;
  logic [CW-1:0]   cnt [NREG];
  logic [NREG-1:0] pend;
  logic [CW-1:0]   busy_cnt;
  state_t          state_q, state_d;

  logic wr_en, raw, waw, struct_hz, issue_c, sb_load, long_issue, drained;

  assign cls  = op_class_t'(id_class);
  assign op_l = CW'(op_lat(cls, 32'(id_long_lat), MEM_LAT, MAX_LAT));

  // x0 is hardwired, and halt never writes even if id_we is set.
  assign wr_en = id_we && (id_rd != '0) && (cls != CLS_HALT);

  assign raw = (id_use_rs1 && (id_rs1 != '0) && (cnt[id_rs1] > FWD_C)) ||
               (id_use_rs2 && (id_rs2 != '0) && (cnt[id_rs2] > FWD_C));
  // A younger write may only proceed once it cannot retire before the older one.
  assign waw       = wr_en && (cnt[id_rd] > op_l);
  assign struct_hz = (cls == CLS_LONG) && (busy_cnt != '0);

  assign issue_c = id_valid && (state_q == RUN) && !raw && !waw && !struct_hz && !ex_redirect;

  assign sb_load    = issue_c && wr_en;
  assign long_issue = issue_c && (cls == CLS_LONG);
  assign drained    = (pend == '0) && (busy_cnt == '0);

  assign cnt[0]  = '0;
  assign pend[0] = 1'b0;

  for (genvar r = 1; r < NREG; r++) begin : g_reg
    logic ld;
    assign ld = sb_load && (id_rd == RW'(r));
    sb_counter #(.CW(CW)) u_cnt (
      .clk      (clk),
      .reset    (reset),
      .load     (ld),
      .load_val (op_l),
      .dec      (1'b1),
      .count    (cnt[r]),
      .nz       (pend[r])
    );
  end

  assign sb_pending = pend;

  // Long unit occupancy: reload on long issue, otherwise count down to idle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      busy_cnt <= '0;
    end else if (long_issue) begin
      busy_cnt <= op_l;
    end else if (busy_cnt != '0) begin
      busy_cnt <= busy_cnt - CW'(1);
    end
  end

  // Halt state register.
  always_ff @(posedge clk) begin
    if (!reset) state_q <= RUN;
    else        state_q <= state_d;
  end

  // Halt sequencing: wait for every in-flight result, then park until reset.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (issue_c && (cls == CLS_HALT)) state_d = DRAIN;
      DRAIN:   if (drained) state_d = HALTED;
      HALTED:  state_d = HALTED;
      default: state_d = RUN;
    endcase
  end

  // Pipeline controls; held in a safe idle pattern while reset is asserted.
  always_comb begin
    issue       = 1'b0;
    stall       = 1'b0;
    bubble      = 1'b1;
    flush_if_id = 1'b0;
    long_busy   = 1'b0;
    halted      = 1'b0;
    if (reset) begin
      issue       = issue_c;
      stall       = !ex_redirect && ((state_q != RUN) || (id_valid && !issue_c));
      bubble      = !issue_c;
      flush_if_id = ex_redirect;
      long_busy   = (busy_cnt != '0);
      halted      = (state_q == HALTED);
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed scenarios with literal expectations
// followed by random traffic, all checked every cycle against a reference model.
module tb_hazard_scoreboard;

  localparam int NREG       = 32;
  localparam int MEM_LAT    = 1;
  localparam int MAX_LAT    = 8;
  localparam int FWD_WINDOW = 1;

  logic clk = 1'b0;
  logic reset;
  logic id_valid, id_use_rs1, id_use_rs2, id_we, ex_redirect;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic [1:0] id_class;
  logic [3:0] id_long_lat;
  logic issue, stall, bubble, flush_if_id, long_busy, halted;
  logic [NREG-1:0] sb_pending;

  always #5 clk = ~clk;

  hazard_scoreboard #(
    .NREG(NREG), .MEM_LAT(MEM_LAT), .MAX_LAT(MAX_LAT), .FWD_WINDOW(FWD_WINDOW)
  ) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_rd(id_rd), .id_we(id_we), .id_class(id_class), .id_long_lat(id_long_lat),
    .ex_redirect(ex_redirect), .issue(issue), .stall(stall), .bubble(bubble),
    .flush_if_id(flush_if_id), .long_busy(long_busy), .halted(halted),
    .sb_pending(sb_pending)
  );

  // Reference model: remaining latency per register, long unit occupancy,
  // and halt phase (0 running, 1 draining, 2 halted).
  int m_cnt [NREG];
  int m_busy;
  int m_phase;

  int total  = 0;
  int passed = 0;

  logic a_issue, a_stall, a_bubble, a_flush, a_lb, a_halted;
  logic [NREG-1:0] a_pend;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic int lat_of(input logic [1:0] c, input logic [3:0] ll);
    if (c == 2'd1) return 1 + MEM_LAT;
    if (c == 2'd2) begin
      if (ll == 0) return 1;
      if (int'(ll) > MAX_LAT) return MAX_LAT;
      return int'(ll);
    end
    return 1;
  endfunction

  // Called at a falling edge with inputs already applied: compare all
  // outputs against the model, then advance the model over the rising edge.
  task automatic cycle();
    logic raw, waw, st, e_wr, e_issue, e_stall, e_bubble, e_flush, e_lb, e_halt, drained;
    logic [NREG-1:0] e_pend;
    int lat;
    #1;
    lat  = lat_of(id_class, id_long_lat);
    e_wr = id_we && (id_rd != 0) && (id_class != 2'd3);
    raw  = (id_use_rs1 && id_rs1 != 0 && m_cnt[id_rs1] > FWD_WINDOW) ||
           (id_use_rs2 && id_rs2 != 0 && m_cnt[id_rs2] > FWD_WINDOW);
    waw  = e_wr && (m_cnt[id_rd] > lat);
    st   = (id_class == 2'd2) && (m_busy != 0);
    e_issue  = id_valid && (m_phase == 0) && !raw && !waw && !st && !ex_redirect;
    e_stall  = !ex_redirect && ((m_phase != 0) || (id_valid && !e_issue));
    e_bubble = !e_issue;
    e_flush  = ex_redirect;
    e_lb     = (m_busy != 0);
    e_halt   = (m_phase == 2);
    if (!reset) begin
      e_issue = 0; e_stall = 0; e_bubble = 1; e_flush = 0; e_lb = 0; e_halt = 0;
    end
    for (int r = 0; r < NREG; r++) e_pend[r] = (m_cnt[r] != 0);

    check("issue", issue, e_issue);
    check("stall", stall, e_stall);
    check("bubble", bubble, e_bubble);
    check("flush_if_id", flush_if_id, e_flush);
    check("long_busy", long_busy, e_lb);
    check("halted", halted, e_halt);
    check("sb_pending", sb_pending, e_pend);
    a_issue = issue; a_stall = stall; a_bubble = bubble; a_flush = flush_if_id;
    a_lb = long_busy; a_halted = halted; a_pend = sb_pending;

    @(posedge clk);
    if (!reset) begin
      for (int r = 0; r < NREG; r++) m_cnt[r] = 0;
      m_busy  = 0;
      m_phase = 0;
    end else begin
      drained = (m_busy == 0);
      for (int r = 0; r < NREG; r++) if (m_cnt[r] != 0) drained = 0;
      for (int r = 0; r < NREG; r++) if (m_cnt[r] > 0) m_cnt[r]--;
      if (m_busy > 0) m_busy--;
      if (e_issue && e_wr) m_cnt[id_rd] = lat;
      if (e_issue && id_class == 2'd2) m_busy = lat;
      if (m_phase == 0 && e_issue && id_class == 2'd3) m_phase = 1;
      else if (m_phase == 1 && drained) m_phase = 2;
    end
    @(negedge clk);
  endtask

  task automatic idle_in();
    id_valid = 0; id_use_rs1 = 0; id_use_rs2 = 0; id_we = 0; ex_redirect = 0;
    id_rs1 = 0; id_rs2 = 0; id_rd = 0; id_class = 0; id_long_lat = 0;
  endtask

  task automatic op(input logic [1:0] c, input int rd, input logic we,
                    input int rs1, input logic u1, input int rs2, input logic u2, input int ll);
    id_valid = 1; id_class = c; id_rd = 5'(rd); id_we = we;
    id_rs1 = 5'(rs1); id_use_rs1 = u1; id_rs2 = 5'(rs2); id_use_rs2 = u2;
    id_long_lat = 4'(ll); ex_redirect = 0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int hc;
    int k;
    for (int r = 0; r < NREG; r++) m_cnt[r] = 0;
    m_busy = 0; m_phase = 0;
    idle_in();
    reset = 0;
    @(posedge clk); @(posedge clk); @(negedge clk);

    // Outputs forced while reset is held.
    op(2'd0, 5, 1, 1, 1, 2, 1, 0);
    cycle();
    check("rst_issue", a_issue, 0);
    check("rst_bubble", a_bubble, 1);
    check("rst_stall", a_stall, 0);
    reset = 1;
    idle_in();
    cycle();
    check("post_rst_pend", a_pend, 0);

    // Dependent ALU pair issues back to back.
    op(2'd0, 5, 1, 1, 1, 2, 1, 0); cycle();
    check("alu1_issue", a_issue, 1);
    op(2'd0, 6, 1, 5, 1, 5, 1, 0); cycle();
    check("alu2_issue", a_issue, 1);
    check("alu2_stall", a_stall, 0);
    idle_in(); cycle(); cycle();

    // Load-use: one stall/bubble cycle.
    op(2'd1, 6, 1, 1, 1, 0, 0, 0); cycle();
    check("lw_issue", a_issue, 1);
    op(2'd0, 7, 1, 6, 1, 0, 0, 0); cycle();
    check("lu_stall", a_stall, 1);
    check("lu_bubble", a_bubble, 1);
    check("lu_pend6", a_pend[6], 1);
    cycle();
    check("lu_issue", a_issue, 1);
    idle_in(); cycle();
    check("lu_pend6_clear", a_pend[6], 0);
    cycle();

    // WAW behind a latency-5 long op.
    op(2'd2, 7, 1, 0, 0, 0, 0, 5); cycle();
    check("long_issue", a_issue, 1);
    op(2'd0, 7, 1, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 4; i++) begin
      cycle();
      check("waw_stall", a_stall, 1);
    end
    cycle();
    check("waw_issue", a_issue, 1);
    idle_in(); repeat (6) cycle();

    // Structural: second long op waits for the unit.
    op(2'd2, 8, 1, 0, 0, 0, 0, 5); cycle();
    check("long_a_issue", a_issue, 1);
    op(2'd2, 9, 1, 0, 0, 0, 0, 2);
    for (int i = 1; i <= 5; i++) begin
      cycle();
      check("struct_stall", a_stall, 1);
      check("struct_busy", a_lb, 1);
    end
    cycle();
    check("long_b_issue", a_issue, 1);
    idle_in(); repeat (4) cycle();

    // Redirect while a dependent instruction is stalled.
    op(2'd2, 11, 1, 0, 0, 0, 0, 4); cycle();
    op(2'd0, 12, 1, 11, 1, 0, 0, 0); cycle();
    check("dep_stall", a_stall, 1);
    ex_redirect = 1; cycle();
    check("redir_flush", a_flush, 1);
    check("redir_stall", a_stall, 0);
    check("redir_issue", a_issue, 0);
    check("redir_bubble", a_bubble, 1);
    check("redir_pend11", a_pend[11], 1);
    idle_in(); cycle(); cycle(); cycle();
    check("redir_pend11_clear", a_pend[11], 0);

    // Redirect beats a halt in ID.
    op(2'd3, 0, 0, 0, 0, 0, 0, 0); ex_redirect = 1; cycle();
    check("halt_redir_issue", a_issue, 0);
    check("halt_redir_flush", a_flush, 1);
    op(2'd0, 1, 1, 0, 0, 0, 0, 0); cycle();
    check("after_redir_run", a_issue, 1);
    idle_in(); cycle();

    // Halt with a latency-6 long op in flight.
    op(2'd2, 12, 1, 0, 0, 0, 0, 6); cycle();
    op(2'd3, 0, 0, 0, 0, 0, 0, 0); cycle();
    check("halt_issue", a_issue, 1);
    idle_in();
    n = 0;
    a_halted = 0;
    while (!a_halted && n < 30) begin
      cycle();
      check("drain_stall", a_stall, 1);
      n++;
    end
    check("halt_latency", n, 7);
    for (int i = 0; i < 3; i++) begin
      op(2'd0, 2, 1, 0, 0, 0, 0, 0);
      cycle();
      check("halted_hold", a_halted, 1);
    end
    reset = 0; cycle();
    check("rst_halted", a_halted, 0);
    check("rst_stall2", a_stall, 0);
    reset = 1;
    op(2'd0, 3, 1, 0, 0, 0, 0, 0); cycle();
    check("post_halt_issue", a_issue, 1);
    check("post_halt_pend", a_pend, 0);
    idle_in(); cycle();

    // x0 is never a hazard nor recorded.
    op(2'd1, 0, 1, 1, 1, 0, 0, 0); cycle();
    check("x0_load_issue", a_issue, 1);
    op(2'd0, 4, 1, 0, 1, 0, 1, 0); cycle();
    check("x0_use_issue", a_issue, 1);
    check("x0_use_stall", a_stall, 0);
    check("x0_pend", a_pend[0], 0);
    idle_in(); cycle();

    // Random traffic over a small register window to provoke hazards.
    hc = 0;
    for (int i = 0; i < 4000; i++) begin
      id_valid    = ($urandom_range(0, 99) < 85);
      k           = $urandom_range(0, 99);
      id_class    = (k < 50) ? 2'd0 : (k < 75) ? 2'd1 : (k < 95) ? 2'd2 : 2'd3;
      id_rd       = 5'($urandom_range(0, 7));
      id_we       = ($urandom_range(0, 9) != 0);
      id_rs1      = 5'($urandom_range(0, 7));
      id_rs2      = 5'($urandom_range(0, 7));
      id_use_rs1  = 1'($urandom_range(0, 1));
      id_use_rs2  = 1'($urandom_range(0, 1));
      id_long_lat = 4'($urandom_range(0, 15));
      ex_redirect = ($urandom_range(0, 99) < 8);
      if (m_phase == 2) hc++; else hc = 0;
      reset = (hc >= 3) ? 1'b0 : ($urandom_range(0, 199) != 0);
      cycle();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
